// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if -- bundle of signals between the data-memory access
// controller and its environment (control unit on one side, word-wide
// synchronous memory on the other).
//
// Request side : req_write, req_read, tam, lim, addr, wdata  -> controller
//                rdata, busy, done, err                      <- controller
// Memory side  : mem_en, mem_we, mem_addr, mem_wdata         <- controller
//                mem_rdata                                    -> controller
//
// Modports:
//   slave  - the controller itself
//   master - everything around it (control unit plus memory)
interface dmem_access_ctrl_if #(
  parameter int MEM_AW = 16
);
  logic              req_write;
  logic              req_read;
  logic [1:0]        tam;
  logic [1:0]        lim;
  logic [63:0]       addr;
  logic [63:0]       wdata;
  logic [63:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  req_write, req_read, tam, lim, addr, wdata, mem_rdata,
    output rdata, busy, done, err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_write, req_read, tam, lim, addr, wdata, mem_rdata,
    input  rdata, busy, done, err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl -- data-memory access controller for a 64-bit core.
// Accepts one load or store at a time, checks natural alignment, performs
// full-word stores directly and sub-word stores as read-modify-write, and
// returns loads sign/zero extended.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - dmem_access_ctrl_if.slave (request, status, memory signals)
//
// Parameter:
//   MEM_AW - memory word-address width (mem_addr = addr[MEM_AW+2:3])
module dmem_access_ctrl #(
  parameter int MEM_AW = 16
) (
  input  logic                clk,
  input  logic                rst,
  dmem_access_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int AW3 = MEM_AW + 3;

  state_t          state_reg, state_next;
  logic            accept;
  logic [AW3-1:0]  addr_reg;
  logic [63:0]     wdata_reg;
  logic [1:0]      tam_reg;
  logic [1:0]      lim_reg;
  logic            is_store_reg;
  logic [63:0]     merge_reg;
  logic [63:0]     rdata_reg;

  logic [2:0]      lane;
  logic [63:0]     load_shift;
  logic [63:0]     load_ext;
  logic [7:0]      store_mask;
  logic [63:0]     store_shift;
  logic [63:0]     merged;

  // Size code is shared by tam and lim: 00 = 8 bytes ... 11 = 1 byte.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b00:   return (a != 3'b000);
      2'b01:   return (a[1:0] != 2'b00);
      2'b10:   return a[0];
      default: return 1'b0;
    endcase
  endfunction

  // Next state; a simultaneous write and read is treated as a write.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_write) begin
          accept = 1'b1;
          if (misaligned(bus.tam, bus.addr[2:0]))
            state_next = ERR;
          else if (bus.tam == 2'b00)
            state_next = WRITE;
          else
            state_next = READ;
        end else if (bus.req_read) begin
          accept     = 1'b1;
          state_next = misaligned(bus.lim, bus.addr[2:0]) ? ERR : READ;
        end
      end
      READ:    state_next = WAIT;
      WAIT:    state_next = is_store_reg ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign lane = addr_reg[2:0];

  // Load path: bring the addressed lane down to bit 0, then extend.
  assign load_shift = bus.mem_rdata >> {lane, 3'b000};

  always_comb begin
    load_ext = load_shift;
    case (lim_reg)
      2'b00: load_ext = load_shift;
      2'b01: load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
      2'b10: load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
      2'b11: load_ext = {56'd0, load_shift[7:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Store path: byte-enable mask plus store data moved up to its lane.
  // A full-word store uses mask FF at lane 0, so it shares the merge mux.
  always_comb begin
    store_mask = 8'hFF;
    case (tam_reg)
      2'b00: store_mask = 8'hFF;
      2'b01: store_mask = 8'h0F << lane;
      2'b10: store_mask = 8'h03 << lane;
      2'b11: store_mask = 8'h01 << lane;
      default: store_mask = 8'hFF;
    endcase
  end

  assign store_shift = wdata_reg << {lane, 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[8*gi +: 8] = store_mask[gi] ? store_shift[8*gi +: 8]
                                                : merge_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      tam_reg      <= '0;
      lim_reg      <= '0;
      is_store_reg <= 1'b0;
      merge_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= bus.addr[AW3-1:0];
        wdata_reg    <= bus.wdata;
        tam_reg      <= bus.tam;
        lim_reg      <= bus.lim;
        is_store_reg <= bus.req_write;
      end
      // Memory data is valid during WAIT (one cycle after the READ strobe).
      if (state_reg == WAIT) begin
        merge_reg <= bus.mem_rdata;
        if (!is_store_reg)
          rdata_reg <= load_ext;
      end
    end
  end

  // Moore outputs: decoded from state only, so an asynchronous reset
  // drops mem_en/mem_we at once.
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.err       = (state_reg == ERR);
  assign bus.mem_en    = (state_reg == READ) || (state_reg == WRITE);
  assign bus.mem_we    = (state_reg == WRITE);
  assign bus.mem_addr  = addr_reg[AW3-1:3];
  assign bus.mem_wdata = (state_reg == WRITE) ? merged : 64'd0;
  assign bus.rdata     = rdata_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl -- directed self-checking bench for dmem_access_ctrl.
// A small word-wide memory model answers read strobes one cycle later and
// commits writes on the clock edge. Expected values are hand-computed.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_access_ctrl_if #(.MEM_AW(16)) bus ();

  dmem_access_ctrl #(.MEM_AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: word 0, 2 and 4 preloaded, all others zero.
  logic [63:0] mem [0:15] = '{
    64'h0000_0000_8000_F0FF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
    64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0,
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0
  };

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      else
        bus.mem_rdata <= mem[bus.mem_addr[3:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present a request at a falling edge; it is sampled on the next rising
  // edge. Returns at the following falling edge (first cycle after accept).
  task automatic issue(input logic w, input logic r, input logic [1:0] t,
                       input logic [1:0] l, input logic [63:0] a,
                       input logic [63:0] d, input string name);
    $display("txn %-14s w=%0b r=%0b tam=%0d lim=%0d addr=%h wdata=%h",
             name, w, r, t, l, a, d);
    bus.req_write = w;
    bus.req_read  = r;
    bus.tam       = t;
    bus.lim       = l;
    bus.addr      = a;
    bus.wdata     = d;
    cyc();
    bus.req_write = 1'b0;
    bus.req_read  = 1'b0;
  endtask

  // Sub-word store: READ, WAIT, WRITE, DONE (done 4 cycles after accept).
  task automatic rmw_store(input logic [1:0] t, input logic [63:0] a,
                           input logic [63:0] d, input logic [63:0] exp_word,
                           input string name);
    issue(1'b1, 1'b0, t, 2'b00, a, d, name);
    check({name, " c1 mem_en"}, 64'(bus.mem_en), 64'd1);
    check({name, " c1 mem_we"}, 64'(bus.mem_we), 64'd0);
    check({name, " c1 mem_addr"}, 64'(bus.mem_addr), 64'(a >> 3));
    cyc();
    check({name, " c2 mem_en"}, 64'(bus.mem_en), 64'd0);
    cyc();
    check({name, " c3 mem_we"}, 64'(bus.mem_we), 64'd1);
    check({name, " c3 mem_wdata"}, bus.mem_wdata, exp_word);
    check({name, " c3 done"}, 64'(bus.done), 64'd0);
    cyc();
    check({name, " c4 done"}, 64'(bus.done), 64'd1);
    cyc();
    check({name, " c5 busy"}, 64'(bus.busy), 64'd0);
    check({name, " mem word"}, mem[a[6:3]], exp_word);
  endtask

  // Load: READ, WAIT, DONE (done 3 cycles after accept).
  task automatic load(input logic [1:0] l, input logic [63:0] a,
                      input logic [63:0] exp, input string name);
    issue(1'b0, 1'b1, 2'b00, l, a, 64'd0, name);
    check({name, " c1 mem_en"}, 64'(bus.mem_en), 64'd1);
    cyc();
    cyc();
    check({name, " c3 done"}, 64'(bus.done), 64'd1);
    check({name, " rdata"}, bus.rdata, exp);
    cyc();
    check({name, " idle busy"}, 64'(bus.busy), 64'd0);
  endtask

  // Misaligned request: one ERR cycle, no memory access, rdata kept.
  task automatic misalign(input logic w, input logic [1:0] sz,
                          input logic [63:0] a, input logic [63:0] keep,
                          input string name);
    issue(w, ~w, sz, sz, a, 64'hFFFF_FFFF_FFFF_FFFF, name);
    check({name, " err"}, 64'(bus.err), 64'd1);
    check({name, " mem_en"}, 64'(bus.mem_en), 64'd0);
    check({name, " done"}, 64'(bus.done), 64'd0);
    cyc();
    check({name, " err gone"}, 64'(bus.err), 64'd0);
    check({name, " busy"}, 64'(bus.busy), 64'd0);
    check({name, " rdata kept"}, bus.rdata, keep);
  endtask

  initial begin
    bus.req_write = 1'b0;
    bus.req_read  = 1'b0;
    bus.tam       = 2'b00;
    bus.lim       = 2'b00;
    bus.addr      = 64'd0;
    bus.wdata     = 64'd0;

    #1 rst = 1'b1;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst err", 64'(bus.err), 64'd0);
    check("rst mem_en", 64'(bus.mem_en), 64'd0);
    check("rst mem_we", 64'(bus.mem_we), 64'd0);
    check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst mem_wdata", bus.mem_wdata, 64'd0);
    check("rst rdata", bus.rdata, 64'd0);
    cyc();
    rst = 1'b0;

    // sb into an all-ones word, lane 3.
    rmw_store(2'b11, 64'h13, 64'hAB, 64'hFFFF_FFFF_ABFF_FFFF, "sb 0x13");

    // sd: done two cycles after acceptance.
    issue(1'b1, 1'b0, 2'b00, 2'b00, 64'h10, 64'h1122_3344_5566_7788, "sd 0x10");
    check("sd c1 mem_en", 64'(bus.mem_en), 64'd1);
    check("sd c1 mem_we", 64'(bus.mem_we), 64'd1);
    check("sd c1 mem_addr", 64'(bus.mem_addr), 64'd2);
    check("sd c1 mem_wdata", bus.mem_wdata, 64'h1122_3344_5566_7788);
    check("sd c1 done", 64'(bus.done), 64'd0);
    cyc();
    check("sd c2 done", 64'(bus.done), 64'd1);
    check("sd c2 mem_we", 64'(bus.mem_we), 64'd0);
    cyc();
    check("sd c3 busy", 64'(bus.busy), 64'd0);
    check("sd mem word", mem[2], 64'h1122_3344_5566_7788);

    // sw into upper half; upper wdata bits must not leak.
    rmw_store(2'b01, 64'h24, 64'hFFFF_FFFF_1122_3344, 64'h1122_3344_89AB_CDEF, "sw 0x24");
    // sh at lane 2 of a zero word.
    rmw_store(2'b10, 64'h1A, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_DEF0_0000, "sh 0x1A");

    load(2'b01, 64'h00, 64'hFFFF_FFFF_8000_F0FF, "lw 0x0");
    load(2'b10, 64'h02, 64'hFFFF_FFFF_FFFF_8000, "lh 0x2");
    load(2'b11, 64'h00, 64'h0000_0000_0000_00FF, "lbu 0x0");
    load(2'b00, 64'h10, 64'h1122_3344_5566_7788, "ld 0x10");
    load(2'b11, 64'h27, 64'h0000_0000_0000_0011, "lbu 0x27");
    load(2'b10, 64'h1A, 64'hFFFF_FFFF_FFFF_DEF0, "lh 0x1A");
    load(2'b01, 64'h24, 64'h0000_0000_1122_3344, "lw 0x24");

    misalign(1'b1, 2'b01, 64'h06, 64'h0000_0000_1122_3344, "sw 0x6");
    misalign(1'b0, 2'b00, 64'h04, 64'h0000_0000_1122_3344, "ld 0x4");
    misalign(1'b0, 2'b10, 64'h01, 64'h0000_0000_1122_3344, "lh 0x1");
    misalign(1'b1, 2'b10, 64'h03, 64'h0000_0000_1122_3344, "sh 0x3");

    // Write and read together: write wins; a read pulse while busy is dropped.
    issue(1'b1, 1'b1, 2'b00, 2'b00, 64'h28, 64'hCAFE_F00D_DEAD_BEEF, "sd+ld 0x28");
    check("both c1 mem_we", 64'(bus.mem_we), 64'd1);
    check("both c1 mem_addr", 64'(bus.mem_addr), 64'd5);
    bus.req_read = 1'b1;
    bus.lim      = 2'b00;
    bus.addr     = 64'h0;
    cyc();
    check("both c2 done", 64'(bus.done), 64'd1);
    cyc();
    bus.req_read = 1'b0;
    check("busy read ignored", 64'(bus.busy), 64'd0);
    check("both rdata kept", bus.rdata, 64'h0000_0000_1122_3344);
    check("both mem word", mem[5], 64'hCAFE_F00D_DEAD_BEEF);

    // Reset while a sub-word store is in WRITE.
    issue(1'b1, 1'b0, 2'b11, 2'b00, 64'h30, 64'h77, "sb 0x30 rst");
    cyc();
    cyc();
    check("rstw c3 mem_we", 64'(bus.mem_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rstw mem_we drop", 64'(bus.mem_we), 64'd0);
    check("rstw mem_en drop", 64'(bus.mem_en), 64'd0);
    check("rstw busy", 64'(bus.busy), 64'd0);
    check("rstw rdata", bus.rdata, 64'd0);
    cyc();
    rst = 1'b0;
    check("rstw no write", mem[6], 64'd0);
    check("rstw no done", 64'(bus.done), 64'd0);
    load(2'b11, 64'h27, 64'h0000_0000_0000_0011, "lbu after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
